// File: rtl/eq_serial_cmp.sv
// Bit-serial MSB-first magnitude/equality comparator with saturating equal-result counter.
// Define EQ_SERIAL_CMP_EARLY_EXIT_EN to finish a compare on the first mismatching bit.
module eq_serial_cmp #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned COUNT_W = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               clr_count,
    output logic               busy,
    output logic               done,
    output logic               eq,
    output logic               gt,
    output logic               lt,
    output logic [COUNT_W-1:0] eq_count
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   sa_q, sa_d, sb_q, sb_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               mism_q, mism_d, gtr_q, gtr_d, ltr_q, ltr_d;
    logic               eq_q, eq_d, gt_q, gt_d, lt_q, lt_d;
    logic [COUNT_W-1:0] eqc_q, eqc_d;
    logic               bit_diff, last_bit, first_diff, enter_done;

    always_comb begin
        state_d    = state_q;
        sa_d       = sa_q;
        sb_d       = sb_q;
        cnt_d      = cnt_q;
        mism_d     = mism_q;
        gtr_d      = gtr_q;
        ltr_d      = ltr_q;
        eq_d       = eq_q;
        gt_d       = gt_q;
        lt_d       = lt_q;
        enter_done = 1'b0;
        bit_diff   = sa_q[WIDTH-1] ^ sb_q[WIDTH-1];
        last_bit   = (cnt_q == '0);
        first_diff = bit_diff & ~mism_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    sa_d    = a;
                    sb_d    = b;
                    cnt_d   = CNT_W'(WIDTH - 1);
                    mism_d  = 1'b0;
                    gtr_d   = 1'b0;
                    ltr_d   = 1'b0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                sa_d  = sa_q << 1;
                sb_d  = sb_q << 1;
                cnt_d = cnt_q - CNT_W'(1);
                // Only the first differing bit decides the ordering.
                if (first_diff) begin
                    mism_d = 1'b1;
                    gtr_d  = sa_q[WIDTH-1];
                    ltr_d  = sb_q[WIDTH-1];
                end
`ifdef EQ_SERIAL_CMP_EARLY_EXIT_EN
                enter_done = last_bit | first_diff;
`else
                enter_done = last_bit;
`endif
                if (enter_done) begin
                    state_d = DONE;
                    eq_d    = ~mism_d;
                    gt_d    = gtr_d;
                    lt_d    = ltr_d;
                end
            end
            default: state_d = IDLE;
        endcase

        // Clear takes priority over a coinciding increment.
        if (clr_count)
            eqc_d = '0;
        else if (enter_done && eq_d && (eqc_q != '1))
            eqc_d = eqc_q + COUNT_W'(1);
        else
            eqc_d = eqc_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            cnt_q   <= '0;
            mism_q  <= 1'b0;
            gtr_q   <= 1'b0;
            ltr_q   <= 1'b0;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            eqc_q   <= '0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            cnt_q   <= cnt_d;
            mism_q  <= mism_d;
            gtr_q   <= gtr_d;
            ltr_q   <= ltr_d;
            eq_q    <= eq_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
            eqc_q   <= eqc_d;
        end
    end

    assign busy     = (state_q == SHIFT);
    assign done     = (state_q == DONE);
    assign eq       = eq_q;
    assign gt       = gt_q;
    assign lt       = lt_q;
    assign eq_count = eqc_q;

endmodule

// File: tb/tb_eq_serial_cmp.sv
// Directed self-checking bench for eq_serial_cmp (8-bit counter instance and 2-bit saturating instance).
module tb_eq_serial_cmp;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start, clr_count;
    logic [7:0] a, b;
    logic       busy, done, eq, gt, lt;
    logic [7:0] eq_count;

    logic       start2, clr2;
    logic [7:0] a2, b2;
    logic       busy2, done2, eq2, gt2, lt2;
    logic [1:0] eq_count2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    eq_serial_cmp #(.WIDTH(8), .COUNT_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .a(a), .b(b), .clr_count(clr_count),
        .busy(busy), .done(done), .eq(eq), .gt(gt), .lt(lt), .eq_count(eq_count)
    );

    eq_serial_cmp #(.WIDTH(8), .COUNT_W(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .start(start2), .a(a2), .b(b2), .clr_count(clr2),
        .busy(busy2), .done(done2), .eq(eq2), .gt(gt2), .lt(lt2), .eq_count(eq_count2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulse start for one edge, then wait (bounded) for done and check the result.
    task automatic run_cmp(input string tag, input logic [7:0] av, input logic [7:0] bv,
                           input int exp_lat, input logic exp_eq, input logic exp_gt,
                           input logic exp_lt, input logic [7:0] exp_cnt);
        int k;
        int bc;
        a = av;
        b = bv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        bc = 0;
        while (done !== 1'b1 && k < 40) begin
            if (busy === 1'b1) bc++;
            @(negedge clk);
            k++;
        end
        check({tag, " latency"}, k, exp_lat);
        check({tag, " busy cycles"}, bc, exp_lat);
        check({tag, " busy in done"}, busy, 0);
        check({tag, " eq"}, eq, exp_eq);
        check({tag, " gt"}, gt, exp_gt);
        check({tag, " lt"}, lt, exp_lt);
        check({tag, " eq_count"}, eq_count, exp_cnt);
        @(negedge clk);
        check({tag, " done one cycle"}, done, 0);
    endtask

    initial begin
        int p, d1, d2, ndone;
        logic lt1, eq1, eq2nd;
        logic [1:0] exp_c2 [5];

        reset_n = 1'b0;
        start = 1'b0; clr_count = 1'b0; a = '0; b = '0;
        start2 = 1'b0; clr2 = 1'b0; a2 = '0; b2 = '0;
        repeat (2) @(negedge clk);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset eq", eq, 0);
        check("reset gt", gt, 0);
        check("reset lt", lt, 0);
        check("reset eq_count", eq_count, 0);
        reset_n = 1'b1;
        @(negedge clk);

        run_cmp("eq 5A", 8'h5A, 8'h5A, 8, 1'b1, 1'b0, 1'b0, 8'd1);
`ifdef EQ_SERIAL_CMP_EARLY_EXIT_EN
        run_cmp("gt 80-7F", 8'h80, 8'h7F, 1, 1'b0, 1'b1, 1'b0, 8'd1);
        run_cmp("lt 01-02", 8'h01, 8'h02, 7, 1'b0, 1'b0, 1'b1, 8'd1);
`else
        run_cmp("gt 80-7F", 8'h80, 8'h7F, 8, 1'b0, 1'b1, 1'b0, 8'd1);
        run_cmp("lt 01-02", 8'h01, 8'h02, 8, 1'b0, 1'b0, 1'b1, 8'd1);
`endif

        // Start while busy is ignored; start during the done cycle is accepted.
`ifdef EQ_SERIAL_CMP_EARLY_EXIT_EN
        a = 8'h0E; b = 8'h0F;
`else
        a = 8'h0F; b = 8'hF0;
`endif
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        p = 0; d1 = -1; d2 = -1; ndone = 0;
        lt1 = 1'b0; eq1 = 1'b1; eq2nd = 1'b0;
        while (p < 30) begin
            if (p == 2) begin
                start = 1'b1; a = 8'h00; b = 8'h00;
            end else if (p == 3 || p == d1 + 1) begin
                start = 1'b0;
            end
            if (done === 1'b1) begin
                ndone++;
                if (d1 < 0) begin
                    d1 = p; lt1 = lt; eq1 = eq;
                    start = 1'b1; a = 8'h33; b = 8'h33;
                end else if (d2 < 0) begin
                    d2 = p; eq2nd = eq;
                end
            end
            @(negedge clk);
            p++;
        end
        check("busy-start first done", d1, 8);
        check("busy-start lt", lt1, 1);
        check("busy-start eq", eq1, 0);
        check("done-cycle start latency", d2 - d1, 9);
        check("done-cycle start eq", eq2nd, 1);
        check("busy-start done pulses", ndone, 2);
        check("busy-start eq_count", eq_count, 2);

        // Reset in the middle of an equal compare.
        a = 8'h11; b = 8'h11;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        check("abort eq", eq, 0);
        check("abort gt", gt, 0);
        check("abort lt", lt, 0);
        check("abort eq_count", eq_count, 0);
        reset_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        check("abort no done", ndone, 0);
        check("abort eq_count after", eq_count, 0);

        // Saturation of a 2-bit counter, then clear colliding with an increment.
        exp_c2[0] = 2'd1; exp_c2[1] = 2'd2; exp_c2[2] = 2'd3; exp_c2[3] = 2'd3; exp_c2[4] = 2'd3;
        for (int i = 0; i < 5; i++) begin
            a2 = 8'hC3; b2 = 8'hC3;
            start2 = 1'b1;
            @(negedge clk);
            start2 = 1'b0;
            repeat (8) @(negedge clk);
            check("sat done", done2, 1);
            check("sat eq_count", eq_count2, exp_c2[i]);
            @(negedge clk);
        end
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        repeat (7) @(negedge clk);
        clr2 = 1'b1;
        @(negedge clk);
        clr2 = 1'b0;
        check("clr vs inc done", done2, 1);
        check("clr vs inc eq", eq2, 1);
        check("clr vs inc eq_count", eq_count2, 0);
        @(negedge clk);
        check("clr held eq_count", eq_count2, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/eq_serial_cmp.md
Name: eq_serial_cmp

Overview:
- Parametrised, bit-serial successor to the 1-bit equality comparator.
- Latches two WIDTH-bit operands on a start handshake and compares them MSB-first, one bit per clock.
- Reports equal, greater-than and less-than for operand a relative to b.
- Keeps a saturating count of equal results, for board-level self-test of switch/LED comparator labs.

Parameters:
- WIDTH, 8: operand width in bits; legal range is 1 or more.
- COUNT_W, 8: width of the equal-result counter; legal range is 1 or more.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- start  input  1  request a compare; accepted only while busy=0.
- a  input  WIDTH  operand A; sampled only on the accepting edge.
- b  input  WIDTH  operand B; sampled only on the accepting edge.
- clr_count  input  1  synchronous clear of eq_count.
- busy  output  1  high while a compare is in progress.
- done  output  1  one-cycle pulse when results become valid.
- eq  output  1  a==b for the last completed compare.
- gt  output  1  a>b (unsigned) for the last completed compare.
- lt  output  1  a<b (unsigned) for the last completed compare.
- eq_count  output  COUNT_W  number of completed compares with eq=1; saturates.

Behaviour:
- Reset (reset_n=0 at a rising edge):
  - state goes to IDLE.
  - busy=0, done=0, eq=0, gt=0, lt=0, eq_count=0.
  - Shift registers and bit counter clear.
  - Applies even mid-compare; an aborted compare produces no done pulse and no count update.
- States are IDLE, SHIFT and DONE.
- IDLE:
  - If start=1 at edge E0: latch a and b into shift registers, set bit counter to WIDTH-1, clear the internal mismatch flag, set busy=1, go to SHIFT.
- SHIFT:
  - Each edge compares the MSBs of both shift registers, then shifts both left by one.
  - At the first differing bit, record gt = a-bit and lt = b-bit, and set the mismatch flag. Later bits do not change gt or lt.
  - When the bit counter reaches 0 (edge E_WIDTH), go to DONE.
- DONE (one cycle):
  - Outputs are registered at the transition into DONE.
  - done=1 and busy=0.
  - eq = not mismatch. gt and lt hold the recorded values; both are 0 when eq=1.
  - Exactly one of eq, gt, lt is 1.
  - Next state is IDLE. A start in this cycle is accepted exactly as in IDLE.
- Latency: done is high in the cycle following edge E_WIDTH, i.e. WIDTH+1 edges after the accepting edge counts E0. busy is high for exactly WIDTH cycles.
- eq, gt and lt hold their values until the next done; they are not cleared by a new start.
- start while busy=1 is ignored. Operand changes while busy have no effect.
- eq_count:
  - Increments by 1 on the edge that enters DONE with eq=1.
  - Holds at 2^COUNT_W-1; no wrap.
  - clr_count=1 forces 0. If clr_count and an increment coincide, clr wins and the result is 0.
  - clr_count does not affect the compare in progress.
- WIDTH=1: SHIFT lasts one cycle; done is high in the cycle after E1.

Optional Feature:
- Macro: EQ_SERIAL_CMP_EARLY_EXIT_EN.
- Defined:
  - SHIFT leaves for DONE on the edge that detects the first mismatch.
  - A mismatch at bit i (compared at edge E_{WIDTH-i}) gives done in the cycle after that edge.
  - busy is high for WIDTH-i cycles.
  - Equal operands still take the full WIDTH cycles.
- Undefined: every compare takes exactly WIDTH cycles, as in Behaviour.
- Result values (eq, gt, lt, eq_count) are identical in both builds.

Test Plan:
- WIDTH=8, a=0x5A, b=0x5A, start pulsed at E0 -> done=1 in the cycle after E8; eq=1, gt=0, lt=0; eq_count=1; busy high for 8 cycles.
- a=0x80, b=0x7F -> gt=1, eq=0, lt=0.
  - Macro undefined: done after E8.
  - Macro defined: done after E1, busy high for 1 cycle.
- a=0x01, b=0x02 -> lt=1.
  - Macro defined: mismatch at bit 1, done after E7.
  - Macro undefined: done after E8.
  - eq_count unchanged.
- Start accepted with a=0x0F, b=0xF0. At E3 assert start with a=b=0x00 -> second start ignored; result lt=1, single done pulse. A start in the DONE cycle is accepted, and the next done follows 9 edges later.
- reset_n=0 at E4 of a compare -> next cycle busy=0, done never pulses, eq=gt=lt=0, eq_count=0.
- COUNT_W=2, five equal compares -> eq_count sequence 1,2,3,3,3. Then clr_count=1 on the same edge as a sixth equal done -> eq_count=0.
